// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph patterns
// (active-high, abcdefg) and the scan FSM state encoding.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b1110111;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b0011111;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b1001110;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b0111101;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b1001111;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b1000111;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-high abcdefg segment pattern.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] glyph_c
);

    always_comb begin
        glyph_c = SEG_OFF;
        case (nibble_i)
            4'h0: glyph_c = GLYPH_0;
            4'h1: glyph_c = GLYPH_1;
            4'h2: glyph_c = GLYPH_2;
            4'h3: glyph_c = GLYPH_3;
            4'h4: glyph_c = GLYPH_4;
            4'h5: glyph_c = GLYPH_5;
            4'h6: glyph_c = GLYPH_6;
            4'h7: glyph_c = GLYPH_7;
            4'h8: glyph_c = GLYPH_8;
            4'h9: glyph_c = GLYPH_9;
            4'hA: glyph_c = GLYPH_A;
            4'hB: glyph_c = GLYPH_B;
            4'hC: glyph_c = GLYPH_C;
            4'hD: glyph_c = GLYPH_D;
            4'hE: glyph_c = GLYPH_E;
            4'hF: glyph_c = GLYPH_F;
            default: glyph_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with blanking gaps.
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NDIGITS      = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned COMMON_ANODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] value,
    input  logic [NDIGITS-1:0]   dp_in,
    output logic [SEG_W-1:0]     seg,
    output logic                 dp,
    output logic [NDIGITS-1:0]   digit_en,
    output logic                 frame_done
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NDIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLNK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);
    localparam logic             INV       = (COMMON_ANODE != 0);

    state_e               state_q, state_d;
    logic [VAL_W-1:0]     disp_q;
    logic [NDIGITS-1:0]   dp_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 dpo_q, dpo_d;
    logic [NDIGITS-1:0]   en_q, en_d;
    logic                 frame_q, frame_d;
    logic [3:0]           nib_c;
    logic [SEG_W-1:0]     glyph_c;
    logic                 slot_end_c;
    logic                 suppress_c;

    // Display register: loads accepted regardless of scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            dp_q   <= '0;
        end else if (load) begin
            disp_q <= value;
            dp_q   <= dp_in;
        end
    end

    // Refresh counter and digit index
    assign slot_end_c = (state_q == DRIVE) && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_q == BLNK_LAST) state_d = DRIVE;
            DRIVE:   if (cnt_q == CNT_LAST)  state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    assign nib_c = disp_q[{idx_q, 2'b00} +: 4];

    seg7_glyph u_glyph (
        .nibble_i (nib_c),
        .glyph_c  (glyph_c)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NDIGITS-1:0] lz_c;
    logic               zero_above;

    // lz_c[i]: nibble i and every nibble above it are zero
    always_comb begin
        lz_c       = '0;
        zero_above = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0);
            lz_c[i]    = zero_above;
        end
    end

    assign suppress_c = lz_c[idx_q] && (idx_q != '0);
`else
    assign suppress_c = 1'b0;
`endif

    // FSM outputs, polarity applied before the output registers
    always_comb begin
        seg_d   = SEG_OFF;
        dpo_d   = 1'b0;
        en_d    = '0;
        frame_d = slot_end_c && (idx_q == IDX_LAST);
        if (state_q == DRIVE) begin
            seg_d = suppress_c ? SEG_OFF : glyph_c;
            dpo_d = dp_q[idx_q];
            en_d  = NDIGITS'(1) << idx_q;
        end
        seg_d = seg_d ^ {SEG_W{INV}};
        dpo_d = dpo_d ^ INV;
        en_d  = en_d ^ {NDIGITS{INV}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= {SEG_W{INV}};
            dpo_q   <= INV;
            en_q    <= {NDIGITS{INV}};
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dpo_q;
    assign digit_en   = en_q;
    assign frame_done = frame_q;

endmodule
